// File: rtl/text_mode_pkg.sv
// Shared timing constants and helpers for the 80x30 text-mode fetch path.
// Cell indices are row*COLS+col and fit in 12 bits.
package text_mode_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 30;
  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_TOTAL   = 525;
  localparam int CHAR_BASE = 32;
  localparam int GLYPHS    = 128;
  localparam int CELL_W    = 12;
  localparam int NUM_CELLS = COLS * ROWS;
  localparam int H_CELLS   = H_TOTAL / 8;

  localparam logic [7:0] CHAR_LO = 8'(CHAR_BASE);
  localparam logic [7:0] CHAR_HI = 8'(CHAR_BASE + GLYPHS);

  typedef logic [CELL_W-1:0] cell_idx_t;

  // Owner of the text RAM port in the current cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_DISPLAY,
    SLOT_HOST
  } ram_slot_t;

  // Codes outside the ROM range, and fetches of off-screen cells, render blank.
  function automatic logic glyph_blank(input logic [7:0] code, input logic valid);
    return !valid || (code < CHAR_LO) || (code >= CHAR_HI);
  endfunction

endpackage

// File: rtl/text_host_arb.sv
// Text RAM port arbitration: display slots win, the host takes any other cycle.
// One transaction at a time; the ack cycle itself is never granted.
module text_host_arb
  import text_mode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        display_slot,
  input  logic [11:0] display_addr,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  host_rdata,
  output logic        host_ack,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata
);

  logic      ack_q;
  logic      rd_ok_q;
  logic      grant;
  logic      in_range;
  ram_slot_t slot;

  assign in_range = host_addr < 12'(NUM_CELLS);
  assign grant    = host_req && !ack_q && !display_slot && !rst;

  always_comb begin
    slot = SLOT_IDLE;
    if (display_slot) begin
      slot = SLOT_DISPLAY;
    end else if (grant) begin
      slot = SLOT_HOST;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (slot)
      SLOT_DISPLAY: ram_addr = display_addr;
      SLOT_HOST: begin
        ram_addr  = host_addr;
        ram_we    = host_we & in_range;
        ram_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      ack_q   <= grant;
      rd_ok_q <= grant & !host_we & in_range;
    end
  end

  // RAM read latency is one cycle, so read data lines up with the ack.
  assign host_ack   = ack_q;
  assign host_rdata = rd_ok_q ? ram_rdata : 8'h00;

endmodule

// File: rtl/text_fetch_sched.sv
// Per-cell text fetch: code read at phase 0, glyph address at phase 2,
// glyph byte at phase 3, pixel register reload at phase 7, one pixel per clock.
module text_fetch_sched
  import text_mode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_ack,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_q,
  output logic        pixel,
  output logic        pixel_de
);

  logic [2:0] phase;
  logic [6:0] hcell;
  logic [6:0] tc;
  logic [9:0] tl;
  logic       line_end;
  logic       fetch_valid;
  logic       display_slot;
  logic       de;
  logic       blank;
  cell_idx_t  disp_addr;
  logic [6:0] glyph_idx;

  logic [7:0] code;
  logic [3:0] row;
  logic       valid1;
  logic [7:0] glyph_next;
  logic [7:0] glyph_cur;

  assign phase = hcount[2:0];
  assign hcell = hcount[9:3];

  // Fetch one cell ahead; the last cell of a line prefetches column 0 of the next line.
  assign tc       = (hcell == 7'(H_CELLS - 1)) ? 7'd0 : hcell + 7'd1;
  assign line_end = hcount >= 10'(H_TOTAL - 8);
  assign tl       = !line_end ? vcount :
                    (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;

  assign fetch_valid  = (tc < 7'(COLS)) && (tl < 10'(V_VISIBLE));
  assign display_slot = (phase == 3'd0) && fetch_valid;
  assign disp_addr    = 12'(tl[9:4]) * 12'(COLS) + 12'(tc);
  assign de           = (hcount < 10'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));

  assign blank     = glyph_blank(code, valid1);
  assign glyph_idx = 7'(code - CHAR_LO);
  assign rom_addr  = {glyph_idx, row};

  always_ff @(posedge clk) begin
    if (rst) begin
      code       <= 8'h00;
      row        <= 4'h0;
      valid1     <= 1'b0;
      glyph_next <= 8'h00;
      glyph_cur  <= 8'h00;
      pixel      <= 1'b0;
      pixel_de   <= 1'b0;
    end else begin
      if (phase == 3'd1) begin
        code   <= ram_rdata;
        row    <= tl[3:0];
        valid1 <= fetch_valid;
      end
      if (phase == 3'd3) begin
        glyph_next <= blank ? 8'h00 : rom_q;
      end
      if (phase == 3'd7) begin
        glyph_cur <= glyph_next;
      end
      pixel    <= de & glyph_cur[phase];
      pixel_de <= de;
    end
  end

  text_host_arb u_arb (
    .clk          (clk),
    .rst          (rst),
    .display_slot (display_slot),
    .display_addr (disp_addr),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .ram_rdata    (ram_rdata),
    .host_rdata   (host_rdata),
    .host_ack     (host_ack),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata)
  );

endmodule

// File: doc/text_fetch_sched.md
Name: text_fetch_sched

Overview:
Sequences the per-cell text fetch for 80x30 text mode. Each 8-pixel cell, it reads the character code from the single-port text buffer RAM. It then computes the glyph-ROM row address and reloads the pixel register, producing one pixel per clock. The display has priority on the text RAM; the host port gets every other RAM slot.
The block sits between the VGA timing generator (hcount/vcount) and the text RAM, glyph ROM and DAC. clk is the pixel clock.

Parameters:
COLS, 80, character columns
ROWS, 30, character rows
H_VISIBLE, 640, visible pixels per line
H_TOTAL, 800, pixels per line (must be a multiple of 8)
V_VISIBLE, 480, visible lines
V_TOTAL, 525, lines per frame
CHAR_BASE, 32, first code stored in glyph ROM (128 glyphs x 16 rows)

Ports:
clk  in  1  pixel clock
rst  in  1  reset; synchronous, active-high
hcount  in  10  current pixel x, 0..H_TOTAL-1
vcount  in  10  current line y, 0..V_TOTAL-1
host_req  in  1  host access request; held until host_ack
host_we  in  1  1=write, 0=read
host_addr  in  12  text cell index, row*COLS+col
host_wdata  in  8  write data
host_rdata  out  8  read data, valid with host_ack
host_ack  out  1  one-cycle completion pulse
ram_addr  out  12  text RAM address (combinational)
ram_we  out  1  text RAM write enable
ram_wdata  out  8  text RAM write data
ram_rdata  in  8  text RAM data; synchronous read, 1-cycle latency
rom_addr  out  11  glyph ROM address
rom_q  in  8  glyph byte; 1-cycle latency; bit0 = leftmost pixel
pixel  out  1  registered pixel
pixel_de  out  1  registered visible flag aligned with pixel

Behaviour:
- Phase p = hcount[2:0]. Fetch target column tc = ((hcount>>3)+1) mod (H_TOTAL/8). This gives a one-cell prefetch.
- Target line tl = vcount when hcount < H_TOTAL-8. Otherwise tl = vcount+1, wrapping to 0 at V_TOTAL. This prefetches column 0 of the next line.
- fetch_valid = (tc < COLS) and (tl < V_VISIBLE).
- Phase 0, fetch_valid: display owns the RAM. ram_addr = (tl>>4)*COLS + tc, ram_we=0.
- Phase 1: latch code <= ram_rdata and row <= tl[3:0]. Set valid1 <= fetch_valid from phase 0.
- Phase 2: rom_addr = ((code - CHAR_BASE) << 4) + row, in 11 bits.
  - blank flag = !valid1, or code < CHAR_BASE, or code >= CHAR_BASE+128.
- Phase 3: glyph_next <= blank ? 0 : rom_q.
- Phase 7 edge: glyph_cur <= glyph_next.
- Every cycle:
  - pixel <= de & glyph_cur[p], where de = (hcount < H_VISIBLE) and (vcount < V_VISIBLE).
  - pixel_de <= de.
  - Latency is 1 clock from hcount to pixel.
- Host arbitration:
  - Grant when host_req, no ack pending, and the cycle is not a display slot (phase != 0 or !fetch_valid).
  - In a grant cycle: ram_addr = host_addr, ram_we = host_we & (host_addr < COLS*ROWS), ram_wdata = host_wdata.
  - Next cycle: host_ack=1. host_rdata = ram_rdata for in-range reads, 0 for out-of-range.
  - Out-of-range writes are suppressed but still acked.
  - A req still high in the ack cycle is not granted there. If it is still high the cycle after, it is a new transaction.
  - Worst-case grant wait is 1 cycle.
- Idle RAM cycles: ram_addr=0, ram_we=0, ram_wdata=0.
- Reset:
  - pixel, pixel_de, host_ack, host_rdata, glyph_cur, glyph_next, code, valid1 all 0.
  - A grant in flight at reset produces no ack.
  - ram_we=0 whenever rst=1.
- Simultaneous host write and display fetch to the same cell: the display read in phase 0 returns the old value. The new value is visible on the next frame.

Decomposition:
- Package text_mode_pkg holds the timing constants (COLS, ROWS, H/V totals, CHAR_BASE) and the cell-index width (12).
- One sub-module, text_host_arb: grant/ack logic and RAM port muxing. Inputs are display_slot and the host signals.

Test Plan:
- Reset, then idle: after rst is released, pixel=0, host_ack=0, ram_we=0. No ack for a req asserted during rst.
- Frame render: ram[0]=0x21, ROM row 0 of glyph 1 = 8'h18, at (hcount=0, vcount=0).
  - At hcount=792, vcount=524: ram_addr=0 issued.
  - pixel=1 in the cycles after hcount=3 and hcount=4; 0 for the other six pixels of the cell.
- Row addressing: vcount=37, hcount=0 -> ram_addr = 2*80+1 = 161, and rom_addr row nibble = 5.
- Host write at phase 0, visible: req at hcount=8 -> grant at hcount=9, ack at hcount=10. The ram[5] write is visible on read-back.
- Host read out of range: addr=2400 -> ack with rdata=0, ram_we never asserted.
- Blank codes: code 0x10 and 0xA0 in a visible cell -> all 8 pixels 0. Cells at tc >= 80 (hblank) render 0.
